// File: rtl/bp_error_accumulator.sv
// Lane-wise saturating accumulator that folds per-neuron backprop contributions into one error vector.
// Build option: define BPACC_SHIFT_EN to present err_out arithmetically shifted right by OUT_SHIFT.
module bp_acc_lane #(
  parameter int WIDTH = 32,
  parameter int SHIFT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] out,
  output logic             sat
);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc, nxt;
  logic [WIDTH:0]   sum;

  // One guard bit: sign disagreement between the top two bits means overflow.
  always_comb begin
    sum = {acc[WIDTH-1], acc} + {din[WIDTH-1], din};
    sat = sum[WIDTH] ^ sum[WIDTH-1];
    if (!sat)          nxt = sum[WIDTH-1:0];
    else if (sum[WIDTH]) nxt = MINV;
    else               nxt = MAXV;
  end

  // out is loaded from the next accumulator value so it is ready the cycle DONE is entered.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
      out <= '0;
    end else if (en) begin
      acc <= nxt;
      out <= WIDTH'($signed(nxt) >>> SHIFT);
    end
  end
endmodule

module bp_error_accumulator #(
  parameter int LANES       = 32,
  parameter int WIDTH       = 32,
  parameter int MAX_NEURONS = 32,
  parameter int OUT_SHIFT   = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [$clog2(MAX_NEURONS+1)-1:0]    num_neurons,
  input  logic                                bc_valid,
  output logic                                bc_ready,
  input  logic [LANES-1:0][WIDTH-1:0]         bc_data,
  output logic                                err_valid,
  input  logic                                err_ready,
  output logic [LANES-1:0][WIDTH-1:0]         err_out,
  output logic                                busy,
  output logic                                sat_flag
);
  localparam int CW = $clog2(MAX_NEURONS+1);
  localparam logic [CW-1:0] NMAX = CW'(MAX_NEURONS);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

`ifdef BPACC_SHIFT_EN
  localparam int SHIFT = OUT_SHIFT;
`else
  localparam int SHIFT = 0;
`endif

  if (OUT_SHIFT < 0 || OUT_SHIFT >= WIDTH) begin : g_bad_shift
    $error("OUT_SHIFT must lie in [0, WIDTH)");
  end

  logic [1:0]       state;
  logic [CW-1:0]    remaining, n_eff;
  logic             take, clr;
  logic [LANES-1:0] hit;

  assign bc_ready  = (state == ACCUM);
  assign err_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign take      = bc_valid & bc_ready;
  assign clr       = (state == IDLE) & start;
  assign n_eff     = (num_neurons > NMAX) ? NMAX : num_neurons;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    bp_acc_lane #(.WIDTH(WIDTH), .SHIFT(SHIFT)) u_lane (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (take),
      .din (bc_data[i]),
      .out (err_out[i]),
      .sat (hit[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sat_flag  <= 1'b0;
          remaining <= n_eff;
          state     <= (n_eff == '0) ? DONE : ACCUM;
        end
        ACCUM: if (take) begin
          remaining <= remaining - CW'(1);
          sat_flag  <= sat_flag | (|hit);
          if (remaining == CW'(1)) state <= DONE;
        end
        DONE: if (err_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bp_error_accumulator.sv
// Bench for bp_error_accumulator: table vectors, hand-written corner sequences and random jobs
// checked against an integer-arithmetic model of saturating lane sums.
module tb_bp_error_accumulator;
  localparam int LANES = 32, WIDTH = 32, MAX_NEURONS = 32, OUT_SHIFT = 5;
  localparam int CW = $clog2(MAX_NEURONS+1);
  typedef logic [LANES-1:0][WIDTH-1:0] vec_t;

  logic clk = 0, rst = 1, start = 0, bc_valid = 0, err_ready = 0;
  logic [CW-1:0] num_neurons = '0;
  vec_t bc_data = '0, err_out;
  logic bc_ready, err_valid, busy, sat_flag;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bp_error_accumulator #(.LANES(LANES), .WIDTH(WIDTH), .MAX_NEURONS(MAX_NEURONS),
                         .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rst(rst), .start(start), .num_neurons(num_neurons),
    .bc_valid(bc_valid), .bc_ready(bc_ready), .bc_data(bc_data),
    .err_valid(err_valid), .err_ready(err_ready), .err_out(err_out),
    .busy(busy), .sat_flag(sat_flag));

  // Reference state: plain signed integers, clamped by value.
  longint m_acc [LANES];
  bit     m_sat;
  vec_t   beat_q[$];

  task automatic step(); @(posedge clk); #1; endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      for (int i = 0; i < LANES; i++)
        if (act[i] !== exp[i]) begin
          $display("FAIL %s: lane %0d got %h expected %h", name, i, act[i], exp[i]);
          break;
        end
    end
  endtask

  function automatic logic [WIDTH-1:0] present(input longint v);
    longint r;
`ifdef BPACC_SHIFT_EN
    // floor division by 2^OUT_SHIFT
    r = (v >= 0) ? v / (longint'(1) << OUT_SHIFT)
                 : -((-v + (longint'(1) << OUT_SHIFT) - 1) / (longint'(1) << OUT_SHIFT));
`else
    r = v;
`endif
    return r[WIDTH-1:0];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LANES; i++) m_acc[i] = 0;
    m_sat = 0;
  endfunction

  function automatic void model_beat(input vec_t d);
    longint s, pmax, nmin;
    pmax = longint'(2147483647);
    nmin = -pmax - 1;
    for (int i = 0; i < LANES; i++) begin
      s = m_acc[i] + longint'($signed(d[i]));
      if (s > pmax)      begin s = pmax; m_sat = 1; end
      else if (s < nmin) begin s = nmin; m_sat = 1; end
      m_acc[i] = s;
    end
  endfunction

  function automatic vec_t model_out();
    vec_t v;
    for (int i = 0; i < LANES; i++) v[i] = present(m_acc[i]);
    return v;
  endfunction

  // Runs one job with beats taken from beat_q; returns the result seen while err_valid was high.
  task automatic run_job(input int n, input int stall_pct, input bit poke, input int hold,
                         input string tag, output vec_t res, output bit res_sat);
    int eff, acc_cnt, rdy_cyc, stalls, budget;
    bit poked;
    logic [31:0] junk;
    vec_t snap;
    eff = (n > MAX_NEURONS) ? MAX_NEURONS : n;
    model_reset();
    start = 1; num_neurons = CW'(n); step(); start = 0;
    chk({tag, " busy after start"}, busy, 1);
    acc_cnt = 0; rdy_cyc = 0; stalls = 0; budget = 0; poked = 0;
    while (acc_cnt < eff && budget < 2000) begin
      bc_valid = ($urandom_range(99) >= stall_pct);
      if (poke && !poked) begin
        start = 1; num_neurons = CW'(eff + 3); poked = 1; bc_valid = 0;
      end
      junk = $urandom;
      bc_data = bc_valid ? beat_q[acc_cnt] : {LANES{junk}};
      if (bc_ready) rdy_cyc++;
      if (bc_valid && bc_ready) begin model_beat(beat_q[acc_cnt]); acc_cnt++; end
      else stalls++;
      step(); start = 0; budget++;
    end
    bc_valid = 0;
    chk({tag, " accept within budget"}, budget < 2000, 1);
    chk({tag, " bc_ready every ACCUM cycle"}, rdy_cyc, acc_cnt + stalls);
    chk({tag, " err_valid after last beat"}, err_valid, 1);
    chk({tag, " bc_ready low in DONE"}, bc_ready, 0);
    chk({tag, " sat_flag"}, sat_flag, m_sat);
    chk_vec({tag, " err_out"}, err_out, model_out());
    res = err_out; res_sat = sat_flag;
    snap = err_out;
    err_ready = 0;
    for (int c = 0; c < hold; c++) begin
      step();
      chk({tag, " err_valid held"}, err_valid, 1);
      chk_vec({tag, " err_out stable"}, err_out, snap);
    end
    err_ready = 1; step(); err_ready = 0;
    chk({tag, " err_valid drops"}, err_valid, 0);
    chk({tag, " idle after handshake"}, busy, 0);
  endtask

  typedef struct {
    string       name;
    int          n;
    int          lane;
    logic [31:0] d0, d1, d2;
    logic [31:0] exp;
    bit          exp_sat;
  } tv_t;

  initial begin
    tv_t  tv[6];
    vec_t res, v;
    bit   rs;
    logic [31:0] r;

    tv[0] = '{"basic_sum", 3, 0, 32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0002_0000, 0};
    tv[1] = '{"sat_pos",   2, 5, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0,        32'h7FFF_FFFF, 1};
    tv[2] = '{"sat_neg",   2, 6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1};
    tv[3] = '{"sat_clear", 1, 1, 32'h0000_0005, 32'h0,        32'h0,        32'h0000_0005, 0};
    tv[4] = '{"zero_len",  0, 3, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    tv[5] = '{"post_clamp",3, 7, 32'h7FFF_0000, 32'h7FFF_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1};

    step(); step();
    chk("reset bc_ready", bc_ready, 0);
    chk("reset err_valid", err_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset sat_flag", sat_flag, 0);
    chk_vec("reset err_out", err_out, '0);
    rst = 0; step();

    foreach (tv[k]) begin
      beat_q.delete();
      for (int b = 0; b < 3; b++) begin
        v = '0;
        v[tv[k].lane] = (b == 0) ? tv[k].d0 : (b == 1) ? tv[k].d1 : tv[k].d2;
        beat_q.push_back(v);
      end
      run_job(tv[k].n, 0, 0, 1, tv[k].name, res, rs);
      v = '0; v[tv[k].lane] = present(longint'($signed(tv[k].exp)));
      chk_vec({tv[k].name, " table result"}, res, v);
      chk({tv[k].name, " table sat"}, rs, tv[k].exp_sat);
    end

    // Stalls, long backpressure and an ignored mid-job start.
    beat_q.delete();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < LANES; i++) v[i] = $urandom;
      beat_q.push_back(v);
    end
    run_job(2, 50, 0, 10, "stall_hold", res, rs);
    run_job(4, 20, 1, 2, "ignored_start", res, rs);

    // Reset mid-job: two of four beats taken, the third is dropped with rst.
    model_reset();
    start = 1; num_neurons = CW'(4); step(); start = 0;
    for (int b = 0; b < 2; b++) begin
      bc_valid = 1; bc_data = beat_q[b]; step();
    end
    rst = 1; bc_valid = 1; bc_data = beat_q[2]; step();
    rst = 0; bc_valid = 0;
    chk("mid_rst busy", busy, 0);
    chk("mid_rst bc_ready", bc_ready, 0);
    chk("mid_rst err_valid", err_valid, 0);
    chk("mid_rst sat_flag", sat_flag, 0);
    chk_vec("mid_rst err_out", err_out, '0);
    beat_q.delete();
    for (int i = 0; i < LANES; i++) v[i] = $urandom;
    beat_q.push_back(v);
    run_job(1, 0, 0, 0, "after_rst", res, rs);
    chk_vec("after_rst no residue", res, model_out());

    // num_neurons beyond MAX_NEURONS is clamped.
    beat_q.delete();
    for (int b = 0; b < MAX_NEURONS; b++) begin
      for (int i = 0; i < LANES; i++) begin r = $urandom; v[i] = {{14{r[17]}}, r[17:0]}; end
      beat_q.push_back(v);
    end
    run_job(40, 10, 0, 0, "clamp_40", res, rs);
    run_job(63, 0, 0, 0, "clamp_63", res, rs);

    for (int j = 0; j < 20; j++) begin
      beat_q.delete();
      for (int b = 0; b < 8; b++) begin
        for (int i = 0; i < LANES; i++) begin
          r = $urandom;
          v[i] = ($urandom_range(9) < 4) ? r : {{14{r[17]}}, r[17:0]};
        end
        beat_q.push_back(v);
      end
      run_job($urandom_range(1, 8), 30, 0, $urandom_range(0, 3), "random", res, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_error_accumulator.md
Name: bp_error_accumulator

Overview:
- Sits directly downstream of the layer back-propagation stage; consumes per-neuron backward-contribution vectors (32 lanes x 32 bit, one vector per neuron) one beat at a time.
- Sums the vectors lane-wise with signed saturation to form the error vector for the previous layer, then presents it with a valid/ready handshake.
- Lets one backprop datapath be time-shared across all neurons of a layer.

Parameters:
- LANES, 32, number of lanes per contribution vector (one per previous-layer input)
- WIDTH, 32, bits per lane; signed two's complement Q16.16
- MAX_NEURONS, 32, largest neuron count per job; sets the width of num_neurons
- OUT_SHIFT, 5, arithmetic right shift applied to the outputs when BPACC_SHIFT_EN is defined

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begins a job; sampled only in IDLE
- num_neurons  in  $clog2(MAX_NEURONS+1)  vectors to accumulate; sampled with start
- bc_valid  in  1  contribution vector valid
- bc_ready  out  1  block accepts a vector this cycle
- bc_data  in  [LANES][WIDTH]  contribution vector (lane i = error for previous-layer input i)
- err_valid  out  1  result vector valid
- err_ready  in  1  consumer accepts the result
- err_out  out  [LANES][WIDTH]  accumulated error vector
- busy  out  1  high in any state other than IDLE
- sat_flag  out  1  sticky: at least one lane saturated during the current job

Behaviour:
- Interface timing:
  - One clock, clk. Reset is synchronous and active-high (rst).
- Reset values:
  - State goes to IDLE.
  - All accumulators, err_out and sat_flag are 0.
  - bc_ready=0, err_valid=0, busy=0.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On start=1, clear all accumulators and sat_flag, and load remaining=num_neurons.
  - If num_neurons==0, go to DONE; err_out is then all zeros.
  - Otherwise go to ACCUM.
- ACCUM:
  - bc_ready=1.
  - A beat is accepted on a cycle where bc_valid&&bc_ready.
  - On acceptance, every lane updates acc[i] <= sat(acc[i]+bc_data[i]) and remaining decrements.
  - On accepting the beat that brings remaining to 0, go to DONE.
  - Cycles with bc_valid=0 are stalls; state is held.
- DONE:
  - bc_ready=0, err_valid=1, err_out held stable.
  - On err_valid&&err_ready, go to IDLE; err_valid drops the next cycle.
- Latency:
  - err_valid rises on the cycle after the final beat is accepted.
  - An N-vector job with no stalls occupies ACCUM for exactly N cycles.
- Arithmetic:
  - The sum is formed at WIDTH+1 bits.
  - If the sum exceeds 2^(WIDTH-1)-1, clamp to 0x7FFFFFFF; if it is below -2^(WIDTH-1), clamp to 0x80000000.
  - Any clamp sets sat_flag, which stays set until the next start.
  - A saturated lane keeps accumulating from its clamped value.
- err_out:
  - Registered; driven from the accumulators.
  - Must not change while err_valid=1.
- start outside IDLE is ignored; a job cannot be restarted mid-accumulation.
- num_neurons > MAX_NEURONS: clamp to MAX_NEURONS.
- rst asserted in any state, including mid-ACCUM or DONE awaiting err_ready:
  - Returns to the reset values on the next edge.
  - A beat presented in that cycle is discarded.
- start and a handshake completing in the same cycle: not possible, because start is honoured only in IDLE, where bc_ready=0 and err_valid=0.

Optional Feature:
- Macro BPACC_SHIFT_EN.
- Defined:
  - err_out[i] = acc[i] >>> OUT_SHIFT (arithmetic, sign-preserving; truncates toward -inf).
  - Used to normalise error by learning rate / fan-in before the previous layer's backprop stage.
  - Accumulators and sat_flag are unaffected.
- Not defined: err_out[i] = acc[i] unmodified; OUT_SHIFT is unused.

Test Plan:
- Basic sum: num_neurons=3; lane 0 gets 0x00010000, 0x00020000, 0xFFFF0000 on back-to-back beats -> err_valid on the 4th cycle after the first accept, err_out[0]=0x00020000, sat_flag=0. With BPACC_SHIFT_EN and OUT_SHIFT=5: err_out[0]=0x00001000.
- Stalls and backpressure: num_neurons=2 with bc_valid toggling 1,0,0,1 -> exactly 2 accepts, result correct. Hold err_ready=0 for 10 cycles -> err_valid stays 1 and err_out stays constant.
- Saturation:
  - Lane 5 fed 0x7FFF0000 twice -> err_out[5]=0x7FFFFFFF, sat_flag=1.
  - Lane 6 fed 0x80000000 then 0xFFFFFFFF -> 0x80000000.
  - Next start clears sat_flag.
- Zero-length job: start with num_neurons=0 -> bc_ready never asserts, err_valid=1 on the next cycle, all lanes 0.
- Reset mid-job: assert rst after 2 of 4 beats -> next cycle is IDLE with busy=0 and accumulators 0. A new 1-beat job then returns exactly that beat (no residue).
- Ignored start: pulse start during ACCUM with a different num_neurons -> the original count completes unchanged.
